// File: rtl/password_lock.sv
// Keypad lock: compares codes popped from a FWFT FIFO against a stored password,
// tracks consecutive failures and enforces a timed lockout.
module password_lock #(
  parameter int PASSWORD_LEN   = 4,
  parameter int CODE_WIDTH     = 8,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   empty,
  input  logic [CODE_WIDTH-1:0]                  code,
  output logic                                   rd_en,
  input  logic [PASSWORD_LEN-1:0][CODE_WIDTH-1:0] password,
  output logic [PASSWORD_LEN-1:0]                leds,
  output logic                                   unlocked,
  output logic                                   locked_out,
  output logic                                   alarm,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]      fail_cnt
);

  localparam int IDX_W  = (PASSWORD_LEN > 1) ? $clog2(PASSWORD_LEN) : 1;
  localparam int CNT_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int FAIL_W = $clog2(MAX_ATTEMPTS + 1);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PASSWORD_LEN-1:0] leds_q, leds_d;
  logic [FAIL_W-1:0]       fail_q, fail_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    alarm_q, alarm_d;

  logic [IDX_W-1:0]        exp_idx;
  logic [CODE_WIDTH-1:0]   exp_code;
  logic [FAIL_W-1:0]       fail_inc;

  // First character entered is the most significant password slot.
  assign exp_idx  = IDX_W'(PASSWORD_LEN - 1) - idx_q;
  assign exp_code = password[exp_idx];
  assign fail_inc = fail_q + FAIL_W'(1);

  assign rd_en      = ~empty;
  assign leds       = leds_q;
  assign unlocked   = (state_q == ST_OPEN);
  assign locked_out = (state_q == ST_LOCKOUT);
  assign alarm      = alarm_q;
  assign fail_cnt   = fail_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    leds_d  = leds_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q;
    alarm_d = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (!empty) begin
          if (code == exp_code) begin
            leds_d[idx_q] = 1'b1;
            if (idx_q == IDX_W'(PASSWORD_LEN - 1)) begin
              state_d = ST_OPEN;
              fail_d  = '0;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            idx_d  = '0;
            leds_d = '0;
            fail_d = fail_inc;
            if (fail_inc == FAIL_W'(MAX_ATTEMPTS)) begin
              state_d = ST_LOCKOUT;
              alarm_d = 1'b1;
              cnt_d   = CNT_W'(LOCKOUT_CYCLES - 1);
            end
          end
        end
      end
      ST_OPEN: begin
        // Any key relocks; the key itself is not treated as a first character.
        if (!empty) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
          leds_d  = '0;
        end
      end
      ST_LOCKOUT: begin
        leds_d = '0;
        if (cnt_q == '0) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_ENTRY;
        idx_d   = '0;
        leds_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ENTRY;
      idx_q   <= '0;
      leds_q  <= '0;
      fail_q  <= '0;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      leds_q  <= leds_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

endmodule

// File: tb/tb_password_lock.sv
// Scoreboard bench for password_lock: the driver queues hand-computed expectations,
// a monitor pops and compares them after each clock edge.
module tb_password_lock;

  localparam int PL = 4;
  localparam int CW = 8;
  localparam int MA = 3;
  localparam int LC = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               empty = 1'b1;
  logic [CW-1:0]      code = '0;
  logic               rd_en;
  logic [PL-1:0][CW-1:0] password;
  logic [PL-1:0]      leds;
  logic               unlocked;
  logic               locked_out;
  logic               alarm;
  logic [1:0]         fail_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       rd_en;
    logic [3:0] leds;
    logic       unlocked;
    logic       locked_out;
    logic       alarm;
    logic [1:0] fail_cnt;
  } exp_t;

  exp_t sb[$];

  password_lock #(
    .PASSWORD_LEN(PL), .CODE_WIDTH(CW), .MAX_ATTEMPTS(MA), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .code(code), .rd_en(rd_en),
    .password(password), .leds(leds), .unlocked(unlocked),
    .locked_out(locked_out), .alarm(alarm), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of input and queue the outputs expected after the next edge.
  task automatic step(input logic e, input logic [7:0] c, input logic [3:0] l,
                      input logic u, input logic lo, input logic al, input logic [1:0] f);
    exp_t x;
    @(negedge clk);
    empty = e;
    code  = c;
    x.rd_en = ~e; x.leds = l; x.unlocked = u; x.locked_out = lo; x.alarm = al; x.fail_cnt = f;
    sb.push_back(x);
  endtask

  task automatic unlock_seq(input logic [1:0] f0);
    step(0, 8'h31, 4'b0001, 0, 0, 0, f0);
    step(0, 8'h32, 4'b0011, 0, 0, 0, f0);
    step(0, 8'h33, 4'b0111, 0, 0, 0, f0);
    step(0, 8'h34, 4'b1111, 1, 0, 0, 2'd0);
  endtask

  task automatic relock();
    step(0, 8'h99, 4'b0000, 0, 0, 0, 2'd0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    n_vec++;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
  endtask

  // Assert reset between edges and check the asynchronous clear.
  task automatic do_reset(input string tag);
    drain();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    empty = 1'b1;
    #1;
    chk({tag, "_leds"}, 32'(leds), 32'd0);
    chk({tag, "_unlocked"}, 32'(unlocked), 32'd0);
    chk({tag, "_locked_out"}, 32'(locked_out), 32'd0);
    chk({tag, "_alarm"}, 32'(alarm), 32'd0);
    chk({tag, "_fail_cnt"}, 32'(fail_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: rd_en sampled mid-low-phase, registered outputs just after the edge.
  initial begin
    logic rd_s;
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      rd_s = rd_en;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("rd_en", 32'(rd_s), 32'(x.rd_en));
        chk("leds", 32'(leds), 32'(x.leds));
        chk("unlocked", 32'(unlocked), 32'(x.unlocked));
        chk("locked_out", 32'(locked_out), 32'(x.locked_out));
        chk("alarm", 32'(alarm), 32'(x.alarm));
        chk("fail_cnt", 32'(fail_cnt), 32'(x.fail_cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gap_leds [4];
    logic [7:0] gap_code [4];
    logic [3:0] prev_l;
    password = {8'h31, 8'h32, 8'h33, 8'h34};
    gap_leds = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    gap_code = '{8'h31, 8'h32, 8'h33, 8'h34};

    #3;
    chk("reset_leds", 32'(leds), 32'd0);
    chk("reset_unlocked", 32'(unlocked), 32'd0);
    chk("reset_locked_out", 32'(locked_out), 32'd0);
    chk("reset_alarm", 32'(alarm), 32'd0);
    chk("reset_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("reset_rd_en", 32'(rd_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 8'h31, 4'b0000, 0, 0, 0, 2'd0);
    unlock_seq(2'd0);
    step(1, 8'h00, 4'b1111, 1, 0, 0, 2'd0);

    relock();
    unlock_seq(2'd0);

    relock();
    step(0, 8'h31, 4'b0001, 0, 0, 0, 2'd0);
    step(0, 8'h32, 4'b0011, 0, 0, 0, 2'd0);
    step(0, 8'h40, 4'b0000, 0, 0, 0, 2'd1);
    unlock_seq(2'd1);

    // Three wrong codes; LOCKOUT lasts LC cycles starting with the alarm cycle.
    relock();
    step(0, 8'h00, 4'b0000, 0, 0, 0, 2'd1);
    step(0, 8'h00, 4'b0000, 0, 0, 0, 2'd2);
    step(0, 8'h00, 4'b0000, 0, 1, 1, 2'd3);
    for (int i = 1; i < LC; i++) begin
      if (i <= 4) step(0, gap_code[i-1], 4'b0000, 0, 1, 0, 2'd3);
      else        step(1, 8'h00, 4'b0000, 0, 1, 0, 2'd3);
    end
    step(0, 8'h31, 4'b0000, 0, 0, 0, 2'd0);
    unlock_seq(2'd0);

    relock();
    prev_l = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 2)) step(1, 8'h31, prev_l, 0, 0, 0, 2'd0);
      step(0, gap_code[k], gap_leds[k], (k == 3), 0, 0, 2'd0);
      prev_l = gap_leds[k];
    end
    step(1, 8'h99, 4'b1111, 1, 0, 0, 2'd0);

    relock();
    step(0, 8'h31, 4'b0001, 0, 0, 0, 2'd0);
    step(0, 8'h32, 4'b0011, 0, 0, 0, 2'd0);
    do_reset("rst_entry");
    unlock_seq(2'd0);

    relock();
    step(0, 8'h00, 4'b0000, 0, 0, 0, 2'd1);
    step(0, 8'h00, 4'b0000, 0, 0, 0, 2'd2);
    step(0, 8'h00, 4'b0000, 0, 1, 1, 2'd3);
    step(1, 8'h00, 4'b0000, 0, 1, 0, 2'd3);
    step(1, 8'h00, 4'b0000, 0, 1, 0, 2'd3);
    do_reset("rst_lockout");
    unlock_seq(2'd0);

    drain();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
